command_parser: RTL and testbench

Receive-side companion to the command response generator. Consumes bytes from the UART receiver, passes plaintext letters to the cipher path, and parses `:`-prefixed configuration lines. On each completed command line it commits the new configuration and starts exactly one OK, ERR or query response through the response generator's start/done handshake.

---
 rtl/command_parser.sv | 174 +++++++++++++++++
 tb/tb_command_parser.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/command_parser.sv
// Receive-side byte parser: forwards plaintext letters to the cipher path and
// decodes ':'-prefixed configuration lines into config writes plus one response.
module command_parser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        ch_valid,
  output logic [4:0]  ch_idx,
  output logic        cfg_we,
  output logic [1:0]  cfg_sel,
  output logic [14:0] cfg_data,
  output logic        resp_start,
  output logic        resp_ok,
  output logic        resp_is_query,
  input  logic        resp_done
);

  typedef enum logic [2:0] {
    S_TEXT,
    S_OP,
    S_ARG,
    S_END,
    S_DISCARD,
    S_RESP_WAIT
  } state_t;

  localparam logic [1:0] SEL_ROT = 2'd0;
  localparam logic [1:0] SEL_RNG = 2'd1;
  localparam logic [1:0] SEL_GRD = 2'd2;
  localparam logic [1:0] SEL_POS = 2'd3;

  state_t     state;
  logic [1:0] sel_q;
  logic       query_q;
  logic [4:0] arg_l, arg_m, arg_r;
  logic [1:0] arg_cnt;

  logic       is_upper, is_lower, is_letter, is_term, is_rot_digit;
  logic [4:0] letter_idx, rot_idx;
  logic       arg_valid;
  logic [4:0] arg_val;
  logic       rot_dup;

  // Both letter cases share the same low five bits, offset by one from index 0.
  assign is_upper     = (rx_byte >= 8'h41) && (rx_byte <= 8'h5A);
  assign is_lower     = (rx_byte >= 8'h61) && (rx_byte <= 8'h7A);
  assign is_letter    = is_upper || is_lower;
  assign is_term      = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign is_rot_digit = (rx_byte >= 8'h31) && (rx_byte <= 8'h35);
  assign letter_idx   = rx_byte[4:0] - 5'd1;
  assign rot_idx      = {2'b00, rx_byte[2:0] - 3'd1};

  assign arg_valid = (sel_q == SEL_ROT) ? is_rot_digit : is_letter;
  assign arg_val   = (sel_q == SEL_ROT) ? rot_idx : letter_idx;
  assign rot_dup   = (arg_l == arg_m) || (arg_l == arg_r) || (arg_m == arg_r);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_TEXT;
      sel_q         <= SEL_ROT;
      query_q       <= 1'b0;
      arg_l         <= '0;
      arg_m         <= '0;
      arg_r         <= '0;
      arg_cnt       <= '0;
      ch_valid      <= 1'b0;
      ch_idx        <= '0;
      cfg_we        <= 1'b0;
      cfg_sel       <= '0;
      cfg_data      <= '0;
      resp_start    <= 1'b0;
      resp_ok       <= 1'b0;
      resp_is_query <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only in the cycle
      // they fire; later non-blocking assignments in the same block win.
      ch_valid      <= 1'b0;
      cfg_we        <= 1'b0;
      resp_start    <= 1'b0;
      resp_ok       <= 1'b0;
      resp_is_query <= 1'b0;

      case (state)
        S_TEXT: begin
          if (rx_valid) begin
            if (is_letter) begin
              ch_valid <= 1'b1;
              ch_idx   <= letter_idx;
            end else if (rx_byte == 8'h3A) begin
              query_q <= 1'b0;
              state   <= S_OP;
            end
          end
        end

        S_OP: begin
          if (rx_valid) begin
            arg_cnt <= '0;
            if (rx_byte == 8'h3F) begin
              query_q <= 1'b1;
              state   <= S_END;
            end else if (is_term) begin
              resp_start <= 1'b1;
              state      <= S_RESP_WAIT;
            end else begin
              state <= S_ARG;
              case (rx_byte | 8'h20)
                8'h72:   sel_q <= SEL_ROT;
                8'h6E:   sel_q <= SEL_RNG;
                8'h67:   sel_q <= SEL_GRD;
                8'h70:   sel_q <= SEL_POS;
                default: state <= S_DISCARD;
              endcase
            end
          end
        end

        S_ARG: begin
          if (rx_valid) begin
            if (is_term) begin
              resp_start <= 1'b1;
              state      <= S_RESP_WAIT;
            end else if (!arg_valid) begin
              state <= S_DISCARD;
            end else begin
              case (arg_cnt)
                2'd0:    arg_l <= arg_val;
                2'd1:    arg_m <= arg_val;
                default: arg_r <= arg_val;
              endcase
              arg_cnt <= arg_cnt + 2'd1;
              if (arg_cnt == 2'd2) state <= S_END;
            end
          end
        end

        S_END: begin
          if (rx_valid) begin
            if (is_term) begin
              resp_start <= 1'b1;
              state      <= S_RESP_WAIT;
              if (query_q) begin
                resp_ok       <= 1'b1;
                resp_is_query <= 1'b1;
              end else if (!(sel_q == SEL_ROT && rot_dup)) begin
                cfg_we   <= 1'b1;
                cfg_sel  <= sel_q;
                cfg_data <= {arg_l, arg_m, arg_r};
                resp_ok  <= 1'b1;
              end
            end else begin
              state <= S_DISCARD;
            end
          end
        end

        S_DISCARD: begin
          if (rx_valid && is_term) begin
            resp_start <= 1'b1;
            state      <= S_RESP_WAIT;
          end
        end

        S_RESP_WAIT: begin
          if (resp_done) state <= S_TEXT;
        end

        default: state <= S_TEXT;
      endcase
    end
  end

endmodule

// File: tb/tb_command_parser.sv
// Scoreboard bench for command_parser: expected pulses are queued as bytes are
// driven and matched against the DUT's output pulses as they appear.
module tb_command_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        ch_valid;
  logic [4:0]  ch_idx;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [14:0] cfg_data;
  logic        resp_start;
  logic        resp_ok;
  logic        resp_is_query;
  logic        resp_done;

  command_parser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .ch_valid     (ch_valid),
    .ch_idx       (ch_idx),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .resp_start   (resp_start),
    .resp_ok      (resp_ok),
    .resp_is_query(resp_is_query),
    .resp_done    (resp_done)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_CH, EV_CFG, EV_RESP} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [14:0] a;   // ch_idx or cfg_data
    logic [1:0]  b;   // cfg_sel or {resp_ok, resp_is_query}
  } ev_t;

  ev_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [14:0] exp_cfg  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [14:0] a, input logic [1:0] b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    sb.push_back(e);
  endtask

  task automatic pop_expect(input string tag, input ev_kind_t k, input logic [14:0] a,
                            input logic [1:0] b);
    ev_t e;
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_kind"}, 32'(k), 32'(e.kind));
      check({tag, "_a"}, 32'(a), 32'(e.a));
      check({tag, "_b"}, 32'(b), 32'(e.b));
    end
  endtask

  // Monitor on the falling edge, away from the DUT's register updates.
  always @(negedge clk) begin
    if (ch_valid || cfg_we) check("we_ch_exclusive", 32'(ch_valid && cfg_we), 32'd0);
    if (ch_valid)   pop_expect("ch", EV_CH, {10'd0, ch_idx}, 2'd0);
    if (cfg_we)     pop_expect("cfg", EV_CFG, cfg_data, cfg_sel);
    if (resp_start) pop_expect("resp", EV_RESP, 15'd0, {resp_ok, resp_is_query});
  end

  task automatic send_str(input string s);
    @(negedge clk);
    for (int i = 0; i < s.len(); i++) begin
      rx_byte  = s[i];
      rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int i;
    for (i = 0; i < 20; i++) begin
      if (resp_start) break;
      @(negedge clk);
    end
    if (i == 20) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_resp(input int delay);
    wait_resp();
    repeat (delay) @(negedge clk);
    resp_done = 1'b1;
    @(negedge clk);
    resp_done = 1'b0;
  endtask

  task automatic err_cmd(input string s, input string tag);
    push(EV_RESP, 15'd0, 2'b00);
    send_str(s);
    finish_resp(1);
    check({tag, "_cfg_held"}, 32'(cfg_data), 32'(exp_cfg));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ch_valid"}, 32'(ch_valid), 32'd0);
    check({tag, "_ch_idx"}, 32'(ch_idx), 32'd0);
    check({tag, "_cfg_we"}, 32'(cfg_we), 32'd0);
    check({tag, "_cfg_sel"}, 32'(cfg_sel), 32'd0);
    check({tag, "_cfg_data"}, 32'(cfg_data), 32'd0);
    check({tag, "_resp_start"}, 32'(resp_start), 32'd0);
    check({tag, "_resp_ok"}, 32'(resp_ok), 32'd0);
    check({tag, "_resp_is_query"}, 32'(resp_is_query), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_byte   = 8'h00;
    rx_valid  = 1'b0;
    resp_done = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Plaintext letters, both cases; TERM in TEXT is ignored.
    push(EV_CH, 15'd0, 2'd0);
    push(EV_CH, 15'd25, 2'd0);
    send_str("aZ\015");
    repeat (3) @(negedge clk);

    // Rotor write: '3','2','1' -> 2,1,0; trailing LF after done is ignored.
    push(EV_CFG, {5'd2, 5'd1, 5'd0}, 2'd0);
    push(EV_RESP, 15'd0, 2'b10);
    send_str(":R321\015");
    finish_resp(3);
    exp_cfg = {5'd2, 5'd1, 5'd0};
    send_str("\012");
    check("cfg_after_rot", 32'(cfg_data), 32'(exp_cfg));

    // Position write, bytes delivered in separate bursts.
    push(EV_CFG, {5'd0, 5'd3, 5'd20}, 2'd3);
    push(EV_RESP, 15'd0, 2'b10);
    send_str(":p");
    send_str("ADU");
    send_str("\012");
    finish_resp(0);
    exp_cfg = {5'd0, 5'd3, 5'd20};

    // Query; a byte in the resp_done cycle is dropped, the next is processed.
    push(EV_RESP, 15'd0, 2'b11);
    push(EV_CH, 15'd11, 2'd0);
    send_str(":?\015");
    wait_resp();
    @(negedge clk);
    resp_done = 1'b1;
    rx_byte   = "K";
    rx_valid  = 1'b1;
    @(negedge clk);
    resp_done = 1'b0;
    rx_byte   = "L";
    @(negedge clk);
    rx_valid  = 1'b0;
    repeat (2) @(negedge clk);
    check("cfg_after_query", 32'(cfg_data), 32'(exp_cfg));

    // Rejected commands.
    err_cmd(":R112\015", "rot_dup");
    err_cmd(":R162\015", "rot_range");
    err_cmd(":X\015", "bad_op");
    err_cmd(":NAB\015", "short_arg");
    err_cmd(":NABCD\015", "long_line");
    err_cmd(":\015", "empty_op");

    // Long response hold-off: all bytes dropped, including ':'.
    push(EV_RESP, 15'd0, 2'b00);
    send_str(":G1\015");
    wait_resp();
    send_str("ABC:");
    repeat (46) @(negedge clk);
    resp_done = 1'b1;
    @(negedge clk);
    resp_done = 1'b0;
    push(EV_CH, 15'd16, 2'd0);
    send_str("Q");
    repeat (2) @(negedge clk);

    // Reset mid-command discards the partial line.
    send_str(":G");
    send_str("A");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("mid_reset");
    rst_n   = 1'b1;
    exp_cfg = '0;
    send_str("\015");
    repeat (10) @(negedge clk);
    check("cfg_after_reset", 32'(cfg_data), 32'(exp_cfg));

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
